// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and widths for the UART transmit sequencer
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    START,
    WAIT_DONE,
    GAP
  } seq_state_e;

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// rtl/uart_tx_sequencer_if.sv - producer and UART handshake bundle for the sequencer
interface uart_tx_sequencer_if #(
  parameter int DEPTH = 16
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [UART_DATA_W-1:0] wr_data;
  logic                   wr_en;
  logic                   full;
  logic                   empty;
  logic [CNT_W-1:0]       count;
  logic [UART_DATA_W-1:0] uart_tx;
  logic                   load_data;
  logic                   start_transmit;
  logic                   tx_done;
  logic                   busy;
  logic                   overflow;
  logic                   timeout_err;
  logic                   clr_err;

  modport master (
    output wr_data, wr_en, tx_done, clr_err,
    input  full, empty, count, uart_tx, load_data, start_transmit,
           busy, overflow, timeout_err
  );

  modport slave (
    input  wr_data, wr_en, tx_done, clr_err,
    output full, empty, count, uart_tx, load_data, start_transmit,
           busy, overflow, timeout_err
  );

endinterface

// File: rtl/sync_byte_fifo.sv
// rtl/sync_byte_fifo.sv - byte FIFO with registered count and sticky overflow
module sync_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  input  logic                   clr_err,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   wr_ok;
  logic                   rd_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = mem_q[rd_ptr_q];

  // Pointer/count bookkeeping; a write while full is dropped even if a pop frees a slot this cycle.
  always_comb begin
    wr_ok      = wr_en && !full;
    rd_ok      = rd_en && !empty;
    wr_ptr_d   = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CNT_W'(1);
    end
    overflow_d = overflow_q;
    if (clr_err) begin
      overflow_d = 1'b0;
    end
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
  end

  // Control registers; reset discards the stored contents by zeroing pointers and count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - feeds buffered bytes to the UART load/start handshake one at a time
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int LOAD_CYCLES    = 4,
  parameter int START_CYCLES   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input logic                clk,
  input logic                reset,
  uart_tx_sequencer_if.slave bus
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int PH_MAX = (LOAD_CYCLES >= START_CYCLES && LOAD_CYCLES >= GAP_CYCLES && LOAD_CYCLES >= 2) ? LOAD_CYCLES :
                          (START_CYCLES >= GAP_CYCLES && START_CYCLES >= 2) ? START_CYCLES :
                          (GAP_CYCLES >= 2) ? GAP_CYCLES : 2;
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [PH_W-1:0] LOAD_LAST  = PH_W'(LOAD_CYCLES - 1);
  localparam logic [PH_W-1:0] START_LAST = PH_W'(START_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  seq_state_e             state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [UART_DATA_W-1:0] uart_tx_q, uart_tx_d;
  logic                   load_data_q, load_data_d;
  logic                   start_q, start_d;
  logic                   busy_q, busy_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   tx_done_q, tx_done_d;
  logic                   pop;
  logic                   to_hit;
  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;

  sync_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .clr_err  (bus.clr_err),
    .full     (bus.full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (bus.overflow)
  );

  assign bus.empty          = fifo_empty;
  assign bus.count          = fifo_count;
  assign bus.uart_tx        = uart_tx_q;
  assign bus.load_data      = load_data_q;
  assign bus.start_transmit = start_q;
  assign bus.busy           = busy_q;
  assign bus.timeout_err    = timeout_err_q;

  // Next-state and registered-output decode; strobes are computed for the state being entered.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    to_cnt_d      = to_cnt_q;
    uart_tx_d     = uart_tx_q;
    load_data_d   = 1'b0;
    start_d       = 1'b0;
    timeout_err_d = timeout_err_q;
    tx_done_d     = bus.tx_done;
    pop           = 1'b0;
    to_hit        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          uart_tx_d   = fifo_rd_data;
          state_d     = LOAD;
          phase_d     = '0;
          load_data_d = 1'b1;
        end
      end
      LOAD: begin
        if (phase_q == LOAD_LAST) begin
          state_d = SETUP;
          phase_d = '0;
        end else begin
          phase_d     = phase_q + PH_W'(1);
          load_data_d = 1'b1;
        end
      end
      SETUP: begin
        state_d = START;
        phase_d = '0;
        start_d = 1'b1;
      end
      START: begin
        if (phase_q == START_LAST) begin
          state_d  = WAIT_DONE;
          to_cnt_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
          start_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        // Only a fresh rising edge counts, so a level left high by the UART cannot end the wait.
        if (bus.tx_done && !tx_done_q) begin
          state_d = GAP;
          phase_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          to_hit  = 1'b1;
          state_d = GAP;
          phase_d = '0;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      GAP: begin
        if (phase_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.clr_err) begin
      timeout_err_d = 1'b0;
    end
    if (to_hit) begin
      timeout_err_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      to_cnt_q      <= '0;
      uart_tx_q     <= '0;
      load_data_q   <= 1'b0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      tx_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      to_cnt_q      <= to_cnt_d;
      uart_tx_q     <= uart_tx_d;
      load_data_q   <= load_data_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      tx_done_q     <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb/tb_uart_tx_sequencer.sv - scoreboard bench for uart_tx_sequencer
module tb_uart_tx_sequencer;
  import uart_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en, clr_err, tx_manual, tx_auto, uart_auto;
  logic [7:0] wr_data;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  logic [7:0] exp_q[$];
  int         rise_log[$], rise_cnt[$], wait_log[$], to_log[$], txr_log[$];

  logic       ld_p, st_p, to_p, st_mp;
  logic [7:0] held, exp_b;
  int         cd, hold, e_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_sequencer_if #(.DEPTH(DEPTH)) bus ();

  assign bus.wr_en   = wr_en;
  assign bus.wr_data = wr_data;
  assign bus.clr_err = clr_err;
  assign bus.tx_done = uart_auto ? tx_auto : tx_manual;

  uart_tx_sequencer #(
    .DEPTH(DEPTH), .LOAD_CYCLES(4), .START_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_wr(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    step();
    wr_en = 1'b0;
  endtask

  function automatic int qsize(input int which);
    case (which)
      0: return rise_log.size();
      1: return rise_cnt.size();
      2: return wait_log.size();
      3: return to_log.size();
      default: return txr_log.size();
    endcase
  endfunction

  function automatic int at(input int which, input int i);
    if (i >= qsize(which)) return -1;
    case (which)
      0: return rise_log[i];
      1: return rise_cnt[i];
      2: return wait_log[i];
      3: return to_log[i];
      default: return txr_log[i];
    endcase
  endfunction

  task automatic clear_logs();
    rise_log.delete(); rise_cnt.delete(); wait_log.delete(); to_log.delete(); txr_log.delete();
  endtask

  task automatic wait_for(input int which, input int n, input int budget, input string tag);
    int k = 0;
    while (qsize(which) < n && k < budget) begin
      step();
      k++;
    end
    check(tag, qsize(which), n);
  endtask

  task automatic wait_busy_low(input int budget, input string tag);
    int k = 0;
    while (bus.busy && k < budget) begin
      step();
      k++;
    end
    check(tag, bus.busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_uart_tx"}, bus.uart_tx, 8'h00);
    check({p, "_load"}, bus.load_data, 1'b0);
    check({p, "_start"}, bus.start_transmit, 1'b0);
    check({p, "_busy"}, bus.busy, 1'b0);
    check({p, "_overflow"}, bus.overflow, 1'b0);
    check({p, "_timeout"}, bus.timeout_err, 1'b0);
    check({p, "_empty"}, bus.empty, 1'b1);
    check({p, "_full"}, bus.full, 1'b0);
    check({p, "_count"}, bus.count, 0);
  endtask

  // Output monitor: scoreboard on each load_data rise, plus event logs for timing checks.
  initial begin
    ld_p = 1'b0; st_p = 1'b0; to_p = 1'b0; held = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (bus.load_data && !ld_p) begin
        rise_log.push_back(cyc);
        rise_cnt.push_back(int'(bus.count));
        held = bus.uart_tx;
        check("sb_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          check("sb_byte", bus.uart_tx, exp_b);
        end
      end else if (bus.busy && bus.uart_tx != held) begin
        check("tx_stable", bus.uart_tx, held);
      end
      if (bus.load_data || bus.start_transmit)
        check("strobe_excl", bus.load_data & bus.start_transmit, 1'b0);
      if (st_p && !bus.start_transmit) wait_log.push_back(cyc);
      if (bus.timeout_err && !to_p) to_log.push_back(cyc);
      ld_p = bus.load_data;
      st_p = bus.start_transmit;
      to_p = bus.timeout_err;
    end
  end

  // UART model: pulses tx_done about 100 cycles after each start_transmit rise.
  initial begin
    tx_auto = 1'b0; cd = 0; hold = 0; st_mp = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!uart_auto) begin
        cd = 0; hold = 0; tx_auto = 1'b0;
      end else if (bus.start_transmit && !st_mp) begin
        cd = 100;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          tx_auto = 1'b1;
          hold = 3;
          txr_log.push_back(cyc);
        end
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) tx_auto = 1'b0;
      end
      st_mp = bus.start_transmit;
    end
  end

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete, errors %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    wr_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0; uart_auto = 1'b1; tx_manual = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    reset = 1'b1;
    step();
    step();

    // Single byte: exact strobe timing relative to the write.
    clear_logs();
    push_wr(8'h27, 1'b1);
    check("t1_count_n1", bus.count, 1);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) step();
      check("t1_load", bus.load_data, (k >= 2 && k <= 5));
      check("t1_start", bus.start_transmit, (k >= 7 && k <= 10));
      if (k == 2) check("t1_count_n2", bus.count, 0);
    end
    wait_busy_low(400, "t1_idle");
    check("t1_busy_fall", cyc - at(4, 0), 3);

    // Back-to-back bytes: ordering and spacing after each tx_done.
    clear_logs();
    push_wr(8'h27, 1'b1);
    push_wr(8'h33, 1'b1);
    push_wr(8'h5A, 1'b1);
    check("t2_count_peak", bus.count, 2);
    wait_for(0, 3, 1000, "t2_loads");
    check("t2_gap1", at(0, 1) - at(4, 0), 4);
    check("t2_gap2", at(0, 2) - at(4, 1), 4);
    check("t2_count_pop2", at(1, 1), 1);
    check("t2_count_pop3", at(1, 2), 0);
    wait_busy_low(400, "t2_idle");

    // Overflow with a silent UART, then the timeout on the byte in flight.
    clear_logs();
    uart_auto = 1'b0;
    tx_manual = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push_wr(8'(8'h40 + i), 1'b1);
      if (i == 15) begin
        check("ovf_not_full", bus.full, 1'b0);
        check("ovf_count15", bus.count, 15);
      end
    end
    check("ovf_full", bus.full, 1'b1);
    check("ovf_count16", bus.count, 16);
    push_wr(8'hEE, 1'b0);
    check("ovf_set", bus.overflow, 1'b1);
    check("ovf_dropped", bus.count, 16);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ovf_clr", bus.overflow, 1'b0);
    wr_en = 1'b1; wr_data = 8'hEF; clr_err = 1'b1;
    step();
    wr_en = 1'b0; clr_err = 1'b0;
    check("ovf_set_wins", bus.overflow, 1'b1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ovf_clr2", bus.overflow, 1'b0);

    wait_for(3, 1, 400, "to_seen");
    check("to_exact", at(3, 0) - at(2, 0), TIMEOUT);
    wait_for(0, 2, 50, "to_next_load");
    check("to_next_byte", at(0, 1) - at(3, 0), 3);

    // tx_done already high when WAIT_DONE starts must not end the wait.
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("to_clr", bus.timeout_err, 1'b0);
    tx_manual = 1'b1;
    wait_for(2, 2, 50, "stuck_entry");
    repeat (60) step();
    check("stuck_no_exit", rise_log.size(), 2);
    check("stuck_busy", bus.busy, 1'b1);
    check("stuck_no_to", bus.timeout_err, 1'b0);
    tx_manual = 1'b0;
    step();
    tx_manual = 1'b1;
    e_cyc = cyc;
    wait_for(0, 3, 50, "stuck_release");
    check("stuck_exit", at(0, 2) - e_cyc, 4);
    tx_manual = 1'b0;

    // Asynchronous reset in the middle of WAIT_DONE, then a fresh byte.
    wait_for(2, 3, 50, "rst_entry");
    repeat (5) step();
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("async");
    exp_q.delete();
    step();
    step();
    reset = 1'b1;
    clear_logs();
    uart_auto = 1'b1;
    step();
    check("post_rst_count", bus.count, 0);
    push_wr(8'hA5, 1'b1);
    wait_for(0, 1, 20, "a5_load");
    wait_busy_low(400, "a5_idle");
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
